// File: rtl/mdu_controller_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_t       : command encoding driven by the EX stage
//   mdu_state_t    : controller sequencing states
//   MDU_DIV_CYCLES : busy cycles of a divide, fixed by the divider width
package mdu_controller_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2
   } mdu_state_t;

   localparam int unsigned MDU_DIV_CYCLES = 32;

endpackage

// File: rtl/mdu_controller_divider.sv
// 32-bit unsigned iterative restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : load operands and perform the first iteration
//   abort             : drop the operation in flight
//   dividend, divisor : operands, sampled only with start
//   quotient          : quotient register
//   remainder         : partial/final remainder register
//   valid             : one-cycle pulse, result ready, during the 32nd cycle after start
module mdu_divider
   import mdu_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        valid
);

   logic [31:0] rem_q, quo_q, dvs_q;
   logic [4:0]  cnt_q;
   logic        running_q, valid_q;

   logic [31:0] step_rem_in, step_quo_in, step_dvs_in;
   logic [32:0] rem_shift;
   logic [31:0] step_rem, step_quo;

   // The first iteration runs on the start edge from the raw inputs, so the
   // 32nd iteration lands one edge before the controller's final busy edge.
   always_comb begin
      step_rem_in = rem_q;
      step_quo_in = quo_q;
      step_dvs_in = dvs_q;
      if (start) begin
         step_rem_in = 32'd0;
         step_quo_in = dividend;
         step_dvs_in = divisor;
      end
      rem_shift = {step_rem_in, step_quo_in[31]};
      if (rem_shift >= {1'b0, step_dvs_in}) begin
         step_rem = 32'(rem_shift - {1'b0, step_dvs_in});
         step_quo = {step_quo_in[30:0], 1'b1};
      end else begin
         step_rem = rem_shift[31:0];
         step_quo = {step_quo_in[30:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         valid_q   <= 1'b0;
      end else if (abort) begin
         running_q <= 1'b0;
         valid_q   <= 1'b0;
      end else if (start) begin
         rem_q     <= step_rem;
         quo_q     <= step_quo;
         dvs_q     <= divisor;
         cnt_q     <= 5'(MDU_DIV_CYCLES - 1);
         running_q <= 1'b1;
         valid_q   <= 1'b0;
      end else if (running_q) begin
         rem_q   <= step_rem;
         quo_q   <= step_quo;
         cnt_q   <= cnt_q - 5'd1;
         valid_q <= (cnt_q == 5'd1);
         if (cnt_q == 5'd1) begin
            running_q <= 1'b0;
         end
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign valid     = valid_q;

endmodule

// File: rtl/mdu_controller.sv
// Multiply/divide unit sequencer; owns the architectural HI/LO registers.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start, op  : command valid and command code from EX
//   a, b       : rs / rt operands
//   cancel     : exception flush, aborts an operation in flight
//   busy       : operation in flight (decoded from state)
//   done       : one-cycle pulse after HI/LO written by MUL/DIV
//   hi, lo     : HI/LO registers
module mdu_controller
   import mdu_controller_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  mdu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_t  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;
   // Divide bookkeeping: sign fix-up and divide-by-zero override.
   logic        a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
   logic [31:0] div_a_q, div_a_d;

   logic        div_start, div_abort, div_valid;
   logic [31:0] div_quo, div_rem;
   logic        op_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [63:0] ext_a, ext_b;

   always_comb begin
      op_signed = (op == MDU_MULT) || (op == MDU_DIV);
      a_neg     = op_signed & a[31];
      b_neg     = op_signed & b[31];
      a_mag     = a_neg ? 32'(-a) : a;
      b_mag     = b_neg ? 32'(-b) : b;
      ext_a     = {{32{a_neg}}, a};
      ext_b     = {{32{b_neg}}, b};
   end

   mdu_divider u_divider (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .abort     (div_abort),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem),
      .valid     (div_valid)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      b_zero_d  = b_zero_q;
      div_a_d   = div_a_q;
      div_start = 1'b0;
      div_abort = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && !cancel) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     prod_d  = ext_a * ext_b;
                     cnt_d   = 5'(MUL_CYCLES - 1);
                     state_d = StMul;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     a_neg_d   = a_neg;
                     b_neg_d   = b_neg;
                     b_zero_d  = (b == 32'd0);
                     div_a_d   = a;
                     div_start = 1'b1;
                     state_d   = StDiv;
                  end
                  MDU_MTHI: hi_d = a;
                  MDU_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         StMul: begin
            if (cancel) begin
               state_d = StIdle;
            end else if (cnt_q == 5'd0) begin
               hi_d    = prod_q[63:32];
               lo_d    = prod_q[31:0];
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         StDiv: begin
            if (cancel) begin
               div_abort = 1'b1;
               state_d   = StIdle;
            end else if (div_valid) begin
               if (b_zero_q) begin
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = div_a_q;
               end else begin
                  // 0x80000000 / -1 falls out naturally: magnitude quotient
                  // 0x80000000 with matching signs is left un-negated.
                  lo_d = (a_neg_q ^ b_neg_q) ? 32'(-div_quo) : div_quo;
                  hi_d = a_neg_q ? 32'(-div_rem) : div_rem;
               end
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         prod_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
         div_a_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         b_zero_q <= b_zero_d;
         div_a_q  <= div_a_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller (MUL_CYCLES = 5).
module tb_mdu_controller;
   import mdu_controller_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, cancel;
   mdu_op_t     op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp  = 0;
   int n_fail = 0;

   mdu_controller #(.MUL_CYCLES(5)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // Outputs are sampled and inputs changed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Issue a command, check busy for n cycles, then check the done cycle.
   // Returns in the done cycle so a back-to-back command can be issued.
   task automatic run_op(input string tag, input mdu_op_t o, input logic [31:0] va,
                         input logic [31:0] vb, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int busy_bad;
      start = 1'b1; op = o; a = va; b = vb;
      tick();
      start = 1'b0; op = MDU_NONE;
      busy_bad = 0;
      for (int i = 0; i < n; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
         tick();
      end
      chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      int done_seen;
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MDU_NONE; a = '0; b = '0;
      tick();
      tick();
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      tick();

      // -3 * 7 = -21
      run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      tick();
      chk("mult_done_drop", {31'd0, done}, 32'd0);

      run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE);
      tick();

      // -7 / 2: q = -3, r = -1
      run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      tick();
      run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0, 32'h8000_0000);
      tick();
      run_op("divu", MDU_DIVU, 32'd1000, 32'd7, 32, 32'd6, 32'd142);
      tick();
      run_op("div_mixed", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32, 32'd2, 32'hFFFF_FFF2);
      tick();

      // Divide by zero, then a MULT issued in the done cycle.
      run_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 32, 32'd100, 32'hFFFF_FFFF);
      run_op("b2b_mult", MDU_MULT, 32'd3, 32'd5, 5, 32'd0, 32'd15);
      tick();

      // MTHI while a MULT is in flight is ignored.
      start = 1'b1; op = MDU_MULT; a = 32'd6; b = 32'd7;
      tick();
      op = MDU_MTHI; a = 32'h1234;
      tick();
      start = 1'b0; op = MDU_NONE;
      for (int i = 0; i < 4; i++) tick();
      chk("mthi_busy_done", {31'd0, done}, 32'd1);
      chk("mthi_busy_hi", hi, 32'd0);
      chk("mthi_busy_lo", lo, 32'd42);
      tick();

      // MTLO while idle.
      start = 1'b1; op = MDU_MTLO; a = 32'hABCD;
      tick();
      start = 1'b0; op = MDU_NONE;
      chk("mtlo_lo", lo, 32'hABCD);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      chk("mtlo_done", {31'd0, done}, 32'd0);
      tick();
      chk("mtlo_done_later", {31'd0, done}, 32'd0);

      // Undefined op code is ignored.
      start = 1'b1; op = mdu_op_t'(3'd7); a = 32'h5555;
      tick();
      start = 1'b0; op = MDU_NONE;
      chk("undef_busy", {31'd0, busy}, 32'd0);
      chk("undef_lo", lo, 32'hABCD);

      // Cancel on the 10th busy cycle of a DIV.
      start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
      tick();
      start = 1'b0; op = MDU_NONE;
      for (int i = 0; i < 9; i++) tick();
      chk("cancel_busy_before", {31'd0, busy}, 32'd1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("cancel_busy", {31'd0, busy}, 32'd0);
      chk("cancel_hi", hi, 32'd0);
      chk("cancel_lo", lo, 32'hABCD);
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
         tick();
      end
      chk("cancel_no_done", 32'(done_seen), 32'd0);
      chk("cancel_lo_after", lo, 32'hABCD);

      // Cancel and start together: command dropped.
      cancel = 1'b1; start = 1'b1; op = MDU_MTHI; a = 32'h77;
      tick();
      cancel = 1'b0; start = 1'b0; op = MDU_NONE;
      chk("cancel_start_hi", hi, 32'd0);
      chk("cancel_start_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of a MULT.
      start = 1'b1; op = MDU_MTHI; a = 32'h55;
      tick();
      chk("mthi_idle_hi", hi, 32'h55);
      op = MDU_MULT; a = 32'd3; b = 32'd5;
      tick();
      start = 1'b0; op = MDU_NONE;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("midrst_no_done", {31'd0, done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mdu_controller.md
Name: mdu_controller

Overview:
Sequencing controller for the multiply/divide unit (MDU) of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the EX stage and runs multi-cycle multiply and iterative divide operations. It owns the architectural HI/LO registers and drives busy, which the hazard detection unit uses to stall MDU-dependent instructions. Divide uses an iterative restoring sub-module. Multiply is a registered product released after a fixed latency.

Parameters:
MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..31)
DIV_CYCLES, 32, busy cycles for DIV/DIVU; fixed by the divider iteration count and not overridable

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  command valid this cycle (EX-stage MduStart)
op  in  3  mdu_op_t command
a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
b  in  32  rt operand (divisor / multiplier)
cancel  in  1  abort in-flight operation (exception flush)
busy  out  1  operation in flight
done  out  1  one-cycle pulse, HI/LO just updated by MUL/DIV
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- One clock; reset is synchronous and active-high. Reset, or cancel while idle, changes nothing else.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation abandons the op and applies these values on the next edge.
- States: IDLE, MUL, DIV. busy = (state != IDLE), decoded from state with no extra register.
- IDLE with start=1, sampled at edge E0:
  - MULT/MULTU: capture the 64-bit signed/unsigned product; state goes to MUL; counter loads MUL_CYCLES-1.
  - DIV/DIVU: capture the sign flags; start mdu_divider on the operand magnitudes (signed ops only); state goes to DIV.
  - MTHI/MTLO: write a into hi/lo at E0. No busy, no done.
  - MDU_NONE or undefined op: ignored.
- Latency: busy=1 for exactly N cycles after E0 (N=MUL_CYCLES or 32). At the edge ending the Nth busy cycle: hi/lo written, state returns to IDLE, done=1 for the following cycle only.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Divisor 0: LO = 32'hFFFFFFFF, HI = a (signed and unsigned).
  - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
- start while busy: ignored, including MTHI/MTLO. The hazard unit stalls such instructions; no queueing is performed.
- A new start is accepted in the same cycle that done=1 (back-to-back operation allowed).
- cancel while busy (sampled at an edge): state goes to IDLE next cycle, divider aborted, hi/lo unchanged, no done.
- cancel and start in the same cycle: cancel wins; the command is dropped.
- hi/lo read paths are direct register outputs. No bypass of an in-flight result.

Decomposition:
- Shared package (my_lib.sv): typedef enum logic [2:0] mdu_op_t with MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6; typedef mdu_state_t; constant MDU_DIV_CYCLES=32.
- Sub-module mdu_divider: 32-bit unsigned iterative restoring divider.
  - Ports: clk, reset, start, abort, dividend, divisor.
  - Outputs: quotient, remainder, valid.
  - One quotient bit per cycle; valid pulses after 32 cycles.
  - Sign and divide-by-zero handling stays in mdu_controller.

Test Plan:
1. Assert reset for 2 cycles -> hi=0, lo=0, busy=0, done=0.
2. MULT a=0xFFFFFFFD, b=7 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulse. MULTU a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> 32 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100 after 32 cycles. A MULT issued in the done cycle is accepted, with busy continuous.
5. Issue MTHI a=0x1234 during a MULT -> ignored, and hi ends as the product. MTLO a=0xABCD while idle -> lo=0xABCD next cycle, with busy and done staying 0.
6. cancel on the 10th busy cycle of a DIV -> busy=0 next cycle, hi/lo unchanged, no done. Reset in mid-MULT -> all outputs 0 next cycle.
